// File: rtl/counting_register_file.sv
// Register file with one write port and two tri-state read ports. Each read port
// can add a signed count to its selected register, either before or after the read.
module counting_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int SEL_W    = 8,
    parameter int COUNT_W  = 8,
    parameter int ZERO_REG = 0
) (
    input  logic               clk,
    input  logic               rst,
    output tri   [WIDTH-1:0]   a,
    output tri   [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   in,
    input  logic               ld,
    input  logic [SEL_W-1:0]   sel_a,
    input  logic [SEL_W-1:0]   sel_b,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               oe_a,
    input  logic               oe_b,
    input  logic [COUNT_W-1:0] count_a,
    input  logic [COUNT_W-1:0] count_b,
    input  logic               pre_count_a,
    input  logic               pre_count_b,
    input  logic               post_count_a,
    input  logic               post_count_b,
    output logic               wrap_a,
    output logic               wrap_b
);
    logic [WIDTH-1:0] r_regs [DEPTH];

    logic [WIDTH-1:0] w_rd_a, w_rd_b, w_drv_a, w_drv_b;
    logic             w_val_a, w_val_b, w_val_in;
    logic             w_cnt_a, w_cnt_b, w_same, w_ok_a, w_ok_b;
    logic [WIDTH+1:0] w_sum_a, w_sum_b;

    // Selects past DEPTH, and register 0 when hardwired, read as zero and take no updates.
    function automatic logic f_valid(input logic [SEL_W-1:0] s);
        return (32'(s) < DEPTH) && !((ZERO_REG != 0) && (s == '0));
    endfunction

    assign w_val_a  = f_valid(sel_a);
    assign w_val_b  = f_valid(sel_b);
    assign w_val_in = f_valid(sel_in);

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_val_a && sel_a == SEL_W'(i)) w_rd_a = r_regs[i];
            if (w_val_b && sel_b == SEL_W'(i)) w_rd_b = r_regs[i];
        end
    end

    assign w_drv_a = pre_count_a ? w_rd_a + WIDTH'($signed(count_a)) : w_rd_a;
    assign w_drv_b = pre_count_b ? w_rd_b + WIDTH'($signed(count_b)) : w_rd_b;

    assign a = oe_a ? w_drv_a : 'z;
    assign b = oe_b ? w_drv_b : 'z;

    assign w_cnt_a = pre_count_a | post_count_a;
    assign w_cnt_b = pre_count_b | post_count_b;
    assign w_same  = w_cnt_a && w_cnt_b && (sel_a == sel_b);

    // Two guard bits: any nonzero guard means the sum left [0, 2**WIDTH-1].
    assign w_sum_a = {2'b00, w_rd_a} + (WIDTH+2)'($signed(count_a))
                   + (w_same ? (WIDTH+2)'($signed(count_b)) : '0);
    assign w_sum_b = w_same ? w_sum_a
                   : {2'b00, w_rd_b} + (WIDTH+2)'($signed(count_b));

    assign w_ok_a = w_cnt_a && w_val_a && !(ld && sel_in == sel_a);
    assign w_ok_b = w_cnt_b && w_val_b && !(ld && sel_in == sel_b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            wrap_a <= 1'b0;
            wrap_b <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld && w_val_in && sel_in == SEL_W'(i))
                    r_regs[i] <= in;
                else if (w_ok_a && sel_a == SEL_W'(i))
                    r_regs[i] <= w_sum_a[WIDTH-1:0];
                else if (w_ok_b && sel_b == SEL_W'(i))
                    r_regs[i] <= w_sum_b[WIDTH-1:0];
            end
            if (w_cnt_a) wrap_a <= w_ok_a && (|w_sum_a[WIDTH+1:WIDTH]);
            if (w_cnt_b) wrap_b <= w_ok_b && (|w_sum_b[WIDTH+1:WIDTH]);
        end
    end
endmodule

// File: doc/counting_register_file.md
# counting_register_file

Parametrised general-purpose register file for the CPU datapath: one write port plus two tri-state read ports (A, B), each read port able to apply a signed pre- or post-count to the selected register in the same cycle. It generalises the fixed 32-bit, 2-port register file with configurable width, depth and count width, defined same-register collision rules, an optional hardwired-zero register and registered wrap flags. Used for stack-pointer and index-register style auto-increment/decrement addressing.

## Interface
- WIDTH, 32, register and bus width in bits
- DEPTH, 16, number of registers (1..2**SEL_W)
- SEL_W, 8, select field width
- COUNT_W, 8, width of the signed count operands (COUNT_W <= WIDTH)
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores every write or count

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-low (sampled on rising clk edge)
- a  output (tri)  WIDTH  read port A; high-Z when oe_a = 0
- b  output (tri)  WIDTH  read port B; high-Z when oe_b = 0
- in  input  WIDTH  write data
- ld  input  1  write in to register sel_in
- sel_a, sel_b, sel_in  input  SEL_W  register selects
- oe_a, oe_b  input  1  drive enable for a / b
- count_a, count_b  input  COUNT_W  signed two's-complement count per port
- pre_count_a, pre_count_b  input  1  pre-count request
- post_count_a, post_count_b  input  1  post-count request
- wrap_a, wrap_b  output  1  registered: last count committed by that port wrapped modulo 2**WIDTH

## Operation
- Read value R(x): contents of register x; 0 if x >= DEPTH, or x = 0 with ZERO_REG = 1.
- Port A drive value (B identical): pre_count_a = 1 -> R(sel_a) + sext(count_a); otherwise R(sel_a). Driven only while oe_a = 1; combinational.
- Count commit: on the edge, if pre_count_a or post_count_a, register sel_a <= R(sel_a) + sext(count_a). Pre and post both asserted = one pre-count (count applied once).
- Arithmetic modulo 2**WIDTH; count sign-extended from COUNT_W to WIDTH.
- wrap_a <= 1 when the committed sum crosses 0/2**WIDTH-1 (unsigned carry for positive count, borrow for negative); wrap_a <= 0 on an edge where port A commits without wrap; unchanged when port A does not count.
- Both ports counting the same register: register <= R + sext(count_a) + sext(count_b) (single update, both wraps computed from the combined sum).
- Priority per register on one edge: reset > ld > counts. ld to a register also counted: ld value stored, counts discarded, wrap flags of those ports cleared.
- Writes or counts to out-of-range selects or hardwired-zero register: ignored, wrap flag cleared.
- Port outputs are independent: both ports may read the same register; oe does not gate counting (count with oe = 0 is legal).

## Timing
- Reset: edge with rst = 0 sets every register to 0, wrap_a = wrap_b = 0; a and b still follow oe (reading 0). Reset mid-count discards the count.
- Write latency: ld at edge n -> new value visible on a/b after edge n, zero extra cycles; no write-through within the same cycle (read before edge returns old value).
- Post-count: output shows old value during cycle, incremented value after the edge.
- Pre-count: output shows incremented value in the same cycle, identical value stored at edge.
- Request signals are level-sampled each edge; holding post_count_a for k edges counts k times.
- wrap flags valid one edge after the committing edge.

## Test plan
- Reset then oe_a = oe_b = 1, sel_a = 2, sel_b = 15 -> a = 0, b = 0, wrap_a = wrap_b = 0; oe low -> both high-Z.
- ld 567 to r2, post_count_a sel_a = 2 count 5 for one edge -> a = 572; then count -6 (0xFA) -> a = 566.
- ld 321 to r3, pre_count_a count 2 with no edge -> a = 323; after edge with pre held low -> a = 323.
- ld 0xFFFFFFFE to r4, post-count +3 -> r4 = 1, wrap_a = 1; next post-count -1 -> r4 = 0, wrap_a = 0; post-count -1 -> r4 = 0xFFFFFFFF, wrap_a = 1.
- Same edge: port A +4 and port B -1 on r5 (=10) -> r5 = 13; repeat with ld 100 to r5 -> r5 = 100, wraps 0.
- ZERO_REG = 1: ld 7 to r0 and count on r0 -> reads 0; DEPTH = 16, sel_a = 20 -> a = 0; rst low during active post-count -> all registers 0.
